// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: mode encodings, capture FSM
// states and the pixel packing helpers.
package cam_pkg;

    localparam logic [1:0] MODE_RGB444 = 2'd0;
    localparam logic [1:0] MODE_RGB565 = 2'd1;
    localparam logic [1:0] MODE_GREY   = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        BLANK      = 2'd1,
        LINE       = 2'd2
    } cap_state_e;

    // Callers pass the top four bits of each RGB565 channel.
    function automatic logic [11:0] pack_rgb444(input logic [3:0] r, input logic [3:0] g,
                                                input logic [3:0] b);
        return {r, g, b};
    endfunction

    function automatic logic [11:0] pack_grey12(input logic [3:0] y);
        return {y, y, y};
    endfunction

    function automatic logic [15:0] pack_grey16(input logic [5:0] y);
        return {y[5:1], y, y[5:1]};
    endfunction

endpackage

// File: rtl/cam_decimator.sv
// Modulo counter used for line and pixel decimation; keep_o marks the
// position that survives (count 0).
module cam_decimator #(
    parameter int W = 3
) (
    input  logic         pclk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         adv_i,
    input  logic [W-1:0] wrap_i,
    output logic         keep_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (adv_i) begin
            cnt_q <= (cnt_q == wrap_i) ? '0 : cnt_q + 1'b1;
        end
    end

    assign keep_o = (cnt_q == '0);

endmodule

// File: rtl/ov7670_capture_v2.sv
// OV7670 capture: byte pairing, format select, H/V decimation, bounded writes.
// OV7670_CAPTURE_STATS_EN adds frame and line counters.
//   state      | meaning
//   WAIT_FRAME | idle until a vsync fall with capture_en
//   BLANK      | inside a captured frame, between lines
//   LINE       | href high, pairing bytes into pixels
module ov7670_capture_v2
    import cam_pkg::*;
#(
    parameter int PIX_W   = 12,
    parameter int ADDR_W  = 17,
    parameter int DEPTH   = 76800,
    parameter int DECIM_W = 3
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               href,
    input  logic [7:0]         d,
    input  logic               capture_en,
    input  logic [1:0]         mode,
    input  logic [DECIM_W-1:0] h_decim,
    input  logic [DECIM_W-1:0] v_decim,
    output logic [ADDR_W-1:0]  addr,
    output logic [PIX_W-1:0]   dout,
    output logic               we,
    output logic               frame_done,
    output logic               overflow,
    output logic [15:0]        frame_cnt,
    output logic [11:0]        line_cnt
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic vs_q, vs_d1_q, hr_q, hr_d1_q;
    logic [7:0] d_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_q    <= 1'b0;
            vs_d1_q <= 1'b0;
            hr_q    <= 1'b0;
            hr_d1_q <= 1'b0;
            d_q     <= '0;
        end else begin
            vs_q    <= vsync;
            vs_d1_q <= vs_q;
            hr_q    <= href;
            hr_d1_q <= hr_q;
            d_q     <= d;
        end
    end

    logic vs_fall, href_rise, href_fall, frame_start;
    assign vs_fall   = vs_d1_q & ~vs_q;
    assign href_rise = hr_q & ~hr_d1_q;
    assign href_fall = ~hr_q & hr_d1_q;

    cap_state_e         state_q;
    logic [1:0]         mode_q;
    logic [DECIM_W-1:0] hd_q, vd_q;
    logic               frame_done_q;

    assign frame_start = (state_q == WAIT_FRAME) && vs_fall && capture_en;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_FRAME;
            mode_q       <= MODE_RGB444;
            hd_q         <= '0;
            vd_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (vs_q) begin
                if (state_q != WAIT_FRAME) frame_done_q <= 1'b1;
                state_q <= WAIT_FRAME;
            end else begin
                case (state_q)
                    WAIT_FRAME: if (frame_start) begin
                        state_q <= BLANK;
                        mode_q  <= mode;
                        hd_q    <= h_decim;
                        vd_q    <= v_decim;
                    end
                    BLANK:   if (href_rise) state_q <= LINE;
                    LINE:    if (href_fall) state_q <= BLANK;
                    default: state_q <= WAIT_FRAME;
                endcase
            end
        end
    end

    // A rising href forces phase 0 regardless of where the last line ended.
    logic       phase_q, phase;
    logic [7:0] hi_q;
    assign phase = href_rise ? 1'b0 : phase_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else if (hr_q) begin
            phase_q <= ~phase;
            if (!phase) hi_q <= d_q;
        end
    end

    logic pix_done, h_keep, v_keep;
    assign pix_done = (state_q == LINE) && hr_q && phase;

    cam_decimator #(.W(DECIM_W)) u_hdec (
        .pclk_i (pclk),
        .rst_i  (rst),
        .clr_i  (href_rise),
        .adv_i  (pix_done),
        .wrap_i (hd_q),
        .keep_o (h_keep)
    );

    cam_decimator #(.W(DECIM_W)) u_vdec (
        .pclk_i (pclk),
        .rst_i  (rst),
        .clr_i  (frame_start),
        .adv_i  ((state_q == LINE) && href_fall),
        .wrap_i (vd_q),
        .keep_o (v_keep)
    );

    logic [15:0] fmt16;
    logic [4:0]  unused_bits;
    assign unused_bits = {d_q[0], fmt16[15:12]};

    always_comb begin
        fmt16 = '0;
        case (mode_q)
            MODE_RGB565: fmt16 = (PIX_W == 12) ? {4'h0, hi_q, d_q[7:4]} : {hi_q, d_q};
            MODE_GREY:   fmt16 = (PIX_W == 12) ? {4'h0, pack_grey12(hi_q[7:4])}
                                               : pack_grey16(hi_q[7:2]);
            default:     fmt16 = {4'h0, pack_rgb444(hi_q[7:4], {hi_q[2:0], d_q[7]}, d_q[4:1])};
        endcase
    end

    logic               pix_vld_q, we_q, overflow_q;
    logic [PIX_W-1:0]   pix_q, dout_q;
    logic [ADDR_W-1:0]  addr_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pix_vld_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            pix_vld_q <= pix_done && h_keep && v_keep;
            if (pix_done) pix_q <= fmt16[PIX_W-1:0];
        end
    end

    // Writes are at least two cycles apart, so addr_q has already advanced
    // past the previous write whenever a new pixel arrives.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            dout_q     <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (frame_start) begin
                addr_q     <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (we_q) addr_q <= addr_q + 1'b1;
                if (pix_vld_q) begin
                    if (addr_q < DEPTH_A) begin
                        we_q   <= 1'b1;
                        dout_q <= pix_q;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

`ifdef OV7670_CAPTURE_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [11:0] line_cnt_q, lines_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            line_cnt_q  <= '0;
            lines_q     <= '0;
        end else begin
            if (frame_start) begin
                lines_q <= '0;
            end else if (href_rise && (state_q != WAIT_FRAME) && (lines_q != 12'hFFF)) begin
                lines_q <= lines_q + 1'b1;
            end
            if (frame_done_q) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                line_cnt_q  <= lines_q;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign line_cnt  = line_cnt_q;
`else
    assign frame_cnt = '0;
    assign line_cnt  = '0;
`endif

endmodule

// File: tb/tb_ov7670_capture_v2.sv
// Randomised frame-level bench for ov7670_capture_v2 against a pixel-list model.
module tb_ov7670_capture_v2;

    localparam int PIX_W   = 12;
    localparam int ADDR_W  = 17;
    localparam int DEPTH   = 40;
    localparam int DECIM_W = 3;

    logic               pclk = 1'b0;
    logic               rst, vsync, href, capture_en;
    logic [7:0]         d;
    logic [1:0]         mode;
    logic [DECIM_W-1:0] h_decim, v_decim;
    logic [ADDR_W-1:0]  addr;
    logic [PIX_W-1:0]   dout;
    logic               we, frame_done, overflow;
    logic [15:0]        frame_cnt;
    logic [11:0]        line_cnt;

    always #5 pclk = ~pclk;

    ov7670_capture_v2 #(
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DECIM_W(DECIM_W)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
        .capture_en(capture_en), .mode(mode), .h_decim(h_decim), .v_decim(v_decim),
        .addr(addr), .dout(dout), .we(we), .frame_done(frame_done),
        .overflow(overflow), .frame_cnt(frame_cnt), .line_cnt(line_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int got_addr[$], got_data[$];
    int fd_cnt = 0, t_fd = 0, t_we_first = -1;

    always @(negedge pclk) begin
        if (!rst) begin
            if (we) begin
                got_addr.push_back(int'(addr));
                got_data.push_back(int'(dout));
                if (t_we_first < 0) t_we_first = cyc;
            end
            if (frame_done) begin
                fd_cnt++;
                t_fd = cyc;
            end
        end
    end

    // Reference model state: frame settings frozen at start, expected writes.
    int f_cap, f_mode, f_h, f_v, f_line, f_kept, t_lo_first, t_vs;
    int exp_addr_q[$], exp_data_q[$];
    int exp_addr = 0, exp_ovf = 0, exp_frames = 0, exp_lines = 0;

    function automatic int ref_pixel(input int md, input int w);
        int r5, g6, b5, y;
        r5 = w >> 11;
        g6 = (w >> 5) & 63;
        b5 = w & 31;
        y  = w >> 8;
        case (md)
            1:       return w >> 4;
            2:       return (y / 16) * 'h111;
            default: return ((r5 / 2) * 256) + ((g6 / 4) * 16) + (b5 / 2);
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic frame_start(input int cap, input int md, input int h, input int v);
        vsync = 1'b1;
        href  = 1'b0;
        tick(3);
        mode       = 2'(md);
        h_decim    = DECIM_W'(h);
        v_decim    = DECIM_W'(v);
        capture_en = (cap != 0);
        got_addr.delete();
        got_data.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        fd_cnt     = 0;
        t_we_first = -1;
        t_lo_first = -1;
        f_cap  = cap;
        f_mode = md;
        f_h    = h;
        f_v    = v;
        f_line = 0;
        f_kept = 0;
        vsync  = 1'b0;
        tick(4);
        if (cap != 0) begin
            exp_addr = 0;
            exp_ovf  = 0;
            check_eq("start_addr", int'(addr), 0);
            check_eq("start_overflow", int'(overflow), 0);
        end
    endtask

    task automatic send_line(input int nbytes, input int fixed_en, input int fixed_w);
        int  hi;
        bit  keep_line;
        hi = 0;
        keep_line = (f_line % (f_v + 1)) == 0;
        href = 1'b1;
        for (int j = 0; j < nbytes; j++) begin
            int b;
            if (fixed_en != 0) b = (j % 2 == 0) ? ((fixed_w >> 8) & 255) : (fixed_w & 255);
            else               b = int'($urandom_range(255));
            d = 8'(b);
            if (j % 2 == 0) begin
                hi = b;
            end else begin
                int px;
                px = j / 2;
                if (f_cap != 0 && keep_line && (px % (f_h + 1)) == 0) begin
                    if (t_lo_first < 0) t_lo_first = cyc;
                    if (f_kept < DEPTH) begin
                        exp_addr_q.push_back(f_kept);
                        exp_data_q.push_back(ref_pixel(f_mode, hi * 256 + b));
                    end
                    f_kept++;
                end
            end
            tick(1);
        end
        href = 1'b0;
        d    = 8'h00;
        tick(4);
        f_line++;
    endtask

    task automatic frame_end();
        tick(3);
        vsync = 1'b1;
        t_vs  = cyc;
        tick(6);
        if (f_cap != 0) begin
            exp_addr = (f_kept < DEPTH) ? f_kept : DEPTH;
            exp_ovf  = (f_kept > DEPTH) ? 1 : 0;
            exp_frames++;
            exp_lines = (f_line > 4095) ? 4095 : f_line;
        end
        check_eq("n_writes", got_addr.size(), exp_addr_q.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr_q.size(); i++) begin
            check_eq("wr_addr", got_addr[i], exp_addr_q[i]);
            check_eq("wr_data", got_data[i], exp_data_q[i]);
        end
        check_eq("frame_done_count", fd_cnt, (f_cap != 0) ? 1 : 0);
        if (fd_cnt > 0) check_eq("frame_done_latency", t_fd - t_vs, 2);
        if (t_we_first >= 0 && t_lo_first >= 0)
            check_eq("we_latency", t_we_first - t_lo_first, 3);
        check_eq("overflow", int'(overflow), exp_ovf);
        check_eq("end_addr", int'(addr), exp_addr);
`ifdef OV7670_CAPTURE_STATS_EN
        check_eq("frame_cnt", int'(frame_cnt), exp_frames & 'hFFFF);
        check_eq("line_cnt", int'(line_cnt), exp_lines);
`else
        check_eq("frame_cnt_tied", int'(frame_cnt), 0);
        check_eq("line_cnt_tied", int'(line_cnt), 0);
`endif
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; href = 1'b0; d = 8'h00;
        capture_en = 1'b0; mode = 2'd0; h_decim = '0; v_decim = '0;
        tick(3);
        check_eq("rst_addr", int'(addr), 0);
        check_eq("rst_dout", int'(dout), 0);
        check_eq("rst_we", int'(we), 0);
        check_eq("rst_frame_done", int'(frame_done), 0);
        check_eq("rst_overflow", int'(overflow), 0);
        check_eq("rst_frame_cnt", int'(frame_cnt), 0);
        check_eq("rst_line_cnt", int'(line_cnt), 0);
        rst = 1'b0;
        tick(2);

        // 4 x 8 frame of 0xF81F in RGB444 mode
        frame_start(1, 0, 0, 0);
        repeat (4) send_line(16, 1, 'hF81F);
        frame_end();

        // 2:1 decimation both ways
        frame_start(1, 0, 1, 1);
        repeat (4) send_line(16, 0, 0);
        frame_end();

        // skipped frame leaves addr and status untouched
        frame_start(0, 0, 0, 0);
        repeat (3) send_line(16, 0, 0);
        frame_end();

        // more kept pixels than DEPTH
        frame_start(1, 1, 0, 0);
        repeat (6) send_line(16, 0, 0);
        frame_end();

        // settings changed mid-frame must not apply
        frame_start(1, 2, 0, 0);
        send_line(16, 0, 0);
        mode    = 2'd0;
        h_decim = DECIM_W'(1);
        send_line(16, 0, 0);
        send_line(10, 0, 0);
        frame_end();

        // odd-length lines: the trailing byte is dropped
        frame_start(1, int'($urandom_range(3)), 0, 0);
        repeat (2) send_line(7, 0, 0);
        frame_end();

        // reset in the middle of a line
        frame_start(1, 0, 0, 0);
        send_line(16, 0, 0);
        href = 1'b1;
        for (int j = 0; j < 6; j++) begin
            d = 8'($urandom_range(255));
            tick(1);
        end
        check_eq("pre_rst_addr_nonzero", (addr != '0) ? 1 : 0, 1);
        rst = 1'b1;
        #1;
        check_eq("midrst_addr", int'(addr), 0);
        check_eq("midrst_dout", int'(dout), 0);
        check_eq("midrst_we", int'(we), 0);
        check_eq("midrst_overflow", int'(overflow), 0);
        check_eq("midrst_frame_done", int'(frame_done), 0);
        check_eq("midrst_frame_cnt", int'(frame_cnt), 0);
        check_eq("midrst_line_cnt", int'(line_cnt), 0);
        href = 1'b0;
        tick(2);
        rst = 1'b0;
        exp_addr = 0; exp_ovf = 0; exp_frames = 0; exp_lines = 0;
        got_addr.delete();
        got_data.delete();
        fd_cnt = 0;
        vsync = 1'b1;
        tick(6);
        check_eq("abandoned_no_frame_done", fd_cnt, 0);

        // three 5-line frames for the statistics counters
        for (int f = 0; f < 3; f++) begin
            frame_start(1, int'($urandom_range(3)), int'($urandom_range(3)),
                        int'($urandom_range(3)));
            repeat (5) send_line(12, 0, 0);
            frame_end();
        end

        // free-running random frames
        for (int f = 0; f < 5; f++) begin
            int nl, nb, cap;
            nl  = int'($urandom_range(6, 1));
            nb  = int'($urandom_range(17, 3));
            cap = ($urandom_range(4) != 0) ? 1 : 0;
            frame_start(cap, int'($urandom_range(3)), int'($urandom_range(3)),
                        int'($urandom_range(3)));
            repeat (nl) send_line(nb, 0, 0);
            frame_end();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ov7670_capture_v2.md
# ov7670_capture_v2

Parametrised successor to the single-format camera capture path. It takes OV7670-style parallel video (8-bit data, HREF, VSYNC) on the pixel clock and pairs bytes into pixels. It applies a run-time format select plus independent horizontal and vertical decimation, then emits frame-buffer write strobes with a bounded address. It sits between the camera pins and the dual-port frame buffer; its status outputs feed the display/control logic.

## Interface
- `PIX_W`, default 12: width of `dout`, either 12 or 16.
- `ADDR_W`, default 17: width of `addr`.
- `DEPTH`, default 76800: number of writable buffer words.
- `DECIM_W`, default 3: width of the decimation-factor inputs.

Ports, clock and reset first:
- `pclk`  in  1: camera pixel clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `vsync`  in  1: camera VSYNC, high = vertical blanking.
- `href`  in  1: camera HREF, high = valid bytes.
- `d`  in  8: camera data.
- `capture_en`  in  1: capture the next frame; sampled at frame start.
- `mode`  in  2: 0 = RGB565→RGB444, 1 = RGB565 raw, 2 = grey from YUV422 luma, 3 = reserved (behaves as 0).
- `h_decim`  in  DECIM_W: keep 1 of every (h_decim+1) pixels.
- `v_decim`  in  DECIM_W: keep 1 of every (v_decim+1) lines.
- `addr`  out  ADDR_W: write address.
- `dout`  out  PIX_W: write data.
- `we`  out  1: write strobe, one cycle per pixel.
- `frame_done`  out  1: one-cycle pulse at the end of a captured frame.
- `overflow`  out  1: sticky for the current frame; more than DEPTH pixels were kept.
- `frame_cnt`  out  16: completed captured frames (only with the stats feature compiled in).
- `line_cnt`  out  12: HREF lines seen in the last frame (only with the stats feature compiled in).

## Operation
- Input stage: `vsync`, `href` and `d` are registered on the `pclk` rising edge. All logic below uses the registered copies.
- FSM states: WAIT_FRAME, BLANK, LINE.
  - WAIT_FRAME → BLANK on a registered `vsync` falling edge with `capture_en`=1. The same edge latches `mode`, `h_decim` and `v_decim` into shadow registers; they are frozen for the whole frame.
  - With `capture_en`=0 the FSM stays in WAIT_FRAME and the frame is skipped.
  - BLANK → LINE on an `href` rise.
  - LINE → BLANK on an `href` fall.
  - Any state → WAIT_FRAME on `vsync` high. `frame_done` pulses if the previous state was BLANK or LINE.
- Byte phase:
  - Cleared at each `href` rise and toggles on every `href`-high cycle.
  - Phase 0 latches the high byte. Phase 1 forms the 16-bit word {hi, lo}.
  - An odd trailing byte at an `href` fall is discarded; no write occurs.
- Pixel formatting:
  - Mode 0: the RGB444 value {w[15:12], w[10:7], w[4:1]}, zero-extended at the MSB to PIX_W.
  - Mode 1: the upper PIX_W bits of w.
  - Mode 2: {hi[7:4] ×3} when PIX_W=12, else {hi[7:3], hi[7:2], hi[7:3]}.
- Decimation:
  - Horizontal counter: reset at each line, advances per completed pixel. A pixel is kept when the counter is 0; the counter wraps at `h_decim`.
  - Vertical counter: reset at frame start, advances per `href` fall. The line is kept when the counter is 0; the counter wraps at `v_decim`.
  - A factor of 0 means no decimation.
- Addressing:
  - `addr` is 0 at frame start and increments after each `we`.
  - A kept pixel with `addr` ≥ DEPTH is not written: `we` stays 0 and `overflow` is set. `addr` holds at DEPTH.
  - `overflow` clears at the next frame start.
- `rst` mid-frame: all state clears immediately and the FSM returns to WAIT_FRAME. The frame in progress is abandoned with no `frame_done`.

## Timing
- Reset values: `addr`=0, `dout`=0, `we`=0, `frame_done`=0, `overflow`=0, `frame_cnt`=0, `line_cnt`=0, FSM in WAIT_FRAME.
- Latency: the low byte presented on `d` before edge k produces `we`/`dout`/`addr` valid after edge k+2. Expected address sequence: `we` at addr N, then addr N+1 on the following cycle.
- Maximum write rate is one `we` per 2 `pclk` cycles.
- `frame_done` asserts in the cycle after registered `vsync` is seen high. If the last pixel write coincides with `vsync` rising, the write completes before the pulse.

## Configuration
- `OV7670_CAPTURE_STATS_EN` defined:
  - `frame_cnt` increments (wrapping) with each `frame_done`.
  - `line_cnt` is loaded with the frame's `href`-rise count at `frame_done`; the internal count saturates at 4095.
- Macro undefined: both ports are tied to 0 and no counter logic is built.

## Structure
- Shared package `cam_pkg` holds the mode encodings, the FSM state enum, and the RGB444 and grey packing functions.
- One sub-module, `cam_decimator`: a modulo counter with wrap value and keep flag, instantiated twice (horizontal and vertical).

## Test plan
- Mode 0, no decimation, 4 lines × 8 pixels, every word 0xF81F → 32 writes of 0xF0F, addr 0..31, one `frame_done`.
- `h_decim`=1, `v_decim`=1, 4 × 8 frame → 8 writes, addr 0..7, from lines 0 and 2 and pixels 0, 2, 4, 6.
- DEPTH=10 with a 16-pixel frame → 10 writes, `overflow`=1, `addr` holds at 10; `overflow` is 0 after the next `vsync` fall.
- `capture_en`=0 at `vsync` fall → no `we` and no `frame_done` for that frame; changing `mode` mid-frame has no effect until the next frame.
- 7-byte line → 3 writes, and the 7th byte produces nothing; `rst` pulsed mid-line → all outputs return to reset values at once.
- With `OV7670_CAPTURE_STATS_EN`, three 5-line frames → `frame_cnt`=3, `line_cnt`=5.
